// File: rtl/int_request_controller_pkg.sv
// ----------------------------------------------------------------------------
// Module   : int_ctrl_pkg
// Brief    : Shared types and helpers for the interrupt request controller.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package int_ctrl_pkg;

  localparam int DEF_NUM_SOURCES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // An id field still needs one bit when there is only a single source.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_request_controller_if.sv
// ----------------------------------------------------------------------------
// Module   : int_request_controller_if
// Brief    : Interrupt request / acknowledge / done handshake to the CPU core.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface int_request_controller_if #(
  parameter int ID_WIDTH = 2
) ();

  logic                irq_valid;
  logic [ID_WIDTH-1:0] irq_id;
  logic                irq_ack;
  logic                irq_done;
  logic                in_service;

  modport master (
    output irq_valid,
    output irq_id,
    output in_service,
    input  irq_ack,
    input  irq_done
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    input  in_service,
    output irq_ack,
    output irq_done
  );

endinterface

`default_nettype wire

// File: rtl/int_request_controller_src_latch.sv
// ----------------------------------------------------------------------------
// Module   : int_src_latch
// Brief    : Per-source edge detect, pending bit, sticky miss flag and
//            (with INT_REQ_CTRL_MISS_CNT_EN) a saturating miss counter.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module int_src_latch #(
  parameter int MISS_CNT_WIDTH = 8
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      src_i,
  input  wire logic                      pend_clr_i,
  input  wire logic                      ack_clr_i,
  input  wire logic                      miss_clr_i,
  output logic                           pending_o,
  output logic                           miss_flag_o,
  output logic [MISS_CNT_WIDTH-1:0]      miss_cnt_o
);

  logic src_prev_q;
  logic pending_q, pending_d;
  logic miss_flag_q, miss_flag_d;
  logic evt, clr, miss;

  always_comb begin
    evt         = src_i & ~src_prev_q;
    clr         = pend_clr_i | ack_clr_i;
    miss        = evt & pending_q & ~clr;
    pending_d   = pending_q;
    // A new event always wins over any clear in the same cycle.
    if (evt)
      pending_d = 1'b1;
    else if (clr)
      pending_d = 1'b0;
    miss_flag_d = miss | (miss_flag_q & ~miss_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev_q  <= 1'b0;
      pending_q   <= 1'b0;
      miss_flag_q <= 1'b0;
    end else begin
      src_prev_q  <= src_i;
      pending_q   <= pending_d;
      miss_flag_q <= miss_flag_d;
    end
  end

  assign pending_o   = pending_q;
  assign miss_flag_o = miss_flag_q;

`ifdef INT_REQ_CTRL_MISS_CNT_EN
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_clr_i)
      miss_cnt_d = miss ? MISS_CNT_WIDTH'(1) : '0;
    else if (miss && !(&miss_cnt_q))
      miss_cnt_d = miss_cnt_q + MISS_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      miss_cnt_q <= '0;
    else
      miss_cnt_q <= miss_cnt_d;
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  assign miss_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/int_request_controller.sv
// ----------------------------------------------------------------------------
// Module   : int_request_controller
// Brief    : Latches peripheral interrupt events, picks the highest-priority
//            enabled pending source and hands it to the core via valid/ack.
//            Optional miss counters: INT_REQ_CTRL_MISS_CNT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module int_request_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES    = DEF_NUM_SOURCES,
  parameter int ID_WIDTH       = id_width(NUM_SOURCES),
  parameter int MISS_CNT_WIDTH = 8
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic [NUM_SOURCES-1:0]                int_src_i,
  input  wire logic [NUM_SOURCES-1:0]                int_mask_i,
  input  wire logic                                  gie_i,
  input  wire logic [NUM_SOURCES-1:0]                pend_clr_i,
  input  wire logic [NUM_SOURCES-1:0]                miss_clr_i,
  output logic [NUM_SOURCES-1:0]                     pending_o,
  output logic [NUM_SOURCES-1:0]                     miss_flag_o,
  output logic [NUM_SOURCES*MISS_CNT_WIDTH-1:0]      miss_cnt_o,
  int_request_controller_if.master                   irq_if
);

  state_e                  state_q;
  logic                    irq_valid_q;
  logic [ID_WIDTH-1:0]     irq_id_q;
  logic                    in_service_q;

  logic [NUM_SOURCES-1:0]  ack_clr;
  logic [NUM_SOURCES-1:0]  req;
  logic [ID_WIDTH-1:0]     sel_id;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      ack_clr[i] = (state_q == REQUEST) && irq_if.irq_ack && (irq_id_q == ID_WIDTH'(i));
  end

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      int_src_latch #(
        .MISS_CNT_WIDTH (MISS_CNT_WIDTH)
      ) u_latch (
        .clk         (clk),
        .rst         (rst),
        .src_i       (int_src_i[gi]),
        .pend_clr_i  (pend_clr_i[gi]),
        .ack_clr_i   (ack_clr[gi]),
        .miss_clr_i  (miss_clr_i[gi]),
        .pending_o   (pending_o[gi]),
        .miss_flag_o (miss_flag_o[gi]),
        .miss_cnt_o  (miss_cnt_o[gi*MISS_CNT_WIDTH +: MISS_CNT_WIDTH])
      );
    end
  endgenerate

  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    req    = pending_o & int_mask_i;
    sel_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (req[i])
        sel_id = ID_WIDTH'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_valid_q  <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gie_i && (|req)) begin
            state_q     <= REQUEST;
            irq_valid_q <= 1'b1;
            irq_id_q    <= sel_id;
          end
        end
        REQUEST: begin
          if (irq_if.irq_ack) begin
            state_q      <= SERVICE;
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (irq_if.irq_done) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_valid_q  <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_if.irq_valid  = irq_valid_q;
  assign irq_if.irq_id     = irq_id_q;
  assign irq_if.in_service = in_service_q;

endmodule

`default_nettype wire

// File: doc/int_request_controller.md
Name: int_request_controller

Overview:
- Consumer end of the peripheral interrupt lines: the timer's interrupt_request and other sources.
- Per source: detects rising edges and latches a pending bit; applies per-source masks and a global enable.
- Picks the highest-priority enabled pending source and presents it to the CPU core with a valid/ack request handshake.
- Tracks in-service state until the core signals return-from-interrupt.

Parameters:
- NUM_SOURCES, 4, number of interrupt inputs; index 0 = highest priority.
- ID_WIDTH, $clog2(NUM_SOURCES) (min 1), width of irq_id.
- MISS_CNT_WIDTH, 8, width of each optional missed-event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- int_src  in  NUM_SOURCES  raw interrupt lines, level; an event is a 0->1 transition.
- int_mask  in  NUM_SOURCES  1 = source enabled for delivery.
- gie  in  1  global interrupt enable.
- pend_clr  in  NUM_SOURCES  one-cycle software clear of pending bits.
- miss_clr  in  NUM_SOURCES  one-cycle clear of miss flags (and counters).
- irq_valid  out  1  request to core.
- irq_id  out  ID_WIDTH  source index of the request.
- irq_ack  in  1  core accepts the request (sampled only while irq_valid).
- irq_done  in  1  core finished the ISR (sampled only in SERVICE).
- in_service  out  1  an ISR is active.
- pending  out  NUM_SOURCES  pending bits.
- miss_flag  out  NUM_SOURCES  sticky: an event arrived while already pending.
- miss_cnt  out  NUM_SOURCES*MISS_CNT_WIDTH  optional counters (see Optional Feature).

Behaviour:
- Reset, async, rst=1 forces:
  - all outputs to 0;
  - edge-history register (src_prev) to 0;
  - FSM to IDLE.
  - Consequence: a source already high when rst deasserts is captured as an event.
- Edge detect: event[i] = int_src[i] & ~src_prev[i]; src_prev updates every cycle.
- Pending update per source, priority order:
  - event with pending=1 and no clear this cycle -> pending stays 1, miss_flag set;
  - else event -> pending 1 (set wins over pend_clr and over ack-clear in the same cycle; no miss);
  - else pend_clr or ack-clear -> 0.
- Masked sources still latch pending; unmasking later delivers them.
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE: if gie and any (pending & int_mask) -> latch lowest such index into irq_id, go REQUEST.
  - REQUEST:
    - irq_valid=1; irq_id frozen.
    - Request is never withdrawn: gie/mask/pend_clr changes do not drop irq_valid.
    - On irq_ack -> clear pending[irq_id] (unless a same-cycle event), go SERVICE.
  - SERVICE: in_service=1, irq_valid=0; on irq_done -> IDLE.
  - irq_done outside SERVICE and irq_ack outside REQUEST are ignored.
  - No nesting: higher-priority events during SERVICE stay pending.
- Latency: event sampled at edge N -> pending=1 after edge N+1 -> irq_valid=1 after edge N+2.
  - After irq_done, the next request appears 1 cycle after IDLE is re-entered.
- Priority re-evaluated only in IDLE; fixed priority, no round-robin.
- miss_flag is sticky until miss_clr; miss_clr and a new miss in the same cycle -> flag stays 1.

Optional Feature:
- Macro: INT_REQ_CTRL_MISS_CNT_EN.
- Defined:
  - per-source saturating up-counter of missed events, MISS_CNT_WIDTH bits, saturates at all-ones;
  - cleared by miss_clr[i]; simultaneous miss and clear -> counter = 1.
- Undefined: no counter logic; miss_cnt tied to 0. The port list is unchanged.

Decomposition:
- Package int_ctrl_pkg:
  - FSM state enum (IDLE, REQUEST, SERVICE);
  - function computing ID width with min 1;
  - default NUM_SOURCES constant.
- Sub-module int_src_latch, one instance per source: edge detect, pending bit, miss flag, optional miss counter.
- Top keeps the priority encoder and FSM.

Test Plan:
- Single event, source 2 rises at cycle 10, mask=4'b1111, gie=1 -> pending[2]=1 at 11, irq_valid=1/irq_id=2 at 12; ack at 14 -> pending[2]=0, in_service=1 at 15; done at 20 -> in_service=0 at 21.
- Priority, sources 3 and 1 rise in the same cycle -> irq_id=1 first; after done, irq_id=3 issued.
- Mask/gie:
  - source 0 rises with mask[0]=0 -> pending[0]=1, no irq_valid;
  - set mask[0]=1 -> irq_valid in 1 cycle;
  - gie=0 while in REQUEST -> irq_valid held until ack.
- Miss, source 1 held pending and pulsed 3 more times:
  - miss_flag[1]=1;
  - with INT_REQ_CTRL_MISS_CNT_EN, miss_cnt[1]=3;
  - 300 misses -> 255;
  - miss_clr -> 0.
- Same-cycle edge cases:
  - new event on irq_id coincident with irq_ack -> pending stays 1, re-requested after done;
  - pend_clr with event -> pending=1.
- Reset:
  - rst asserted mid-SERVICE -> immediate IDLE, all outputs 0;
  - int_src[0] high across rst release -> request for id 0 after 2 cycles.
